// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, 8 data bits LSB first, parity, stop.
// Parity arrives precomputed from the upstream even-parity generator.
module parity_frame_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] DIN,
   input  logic       PIN,
   input  logic       VALID,
   output logic       READY,
   output logic       TXD,
   output logic       BUSY,
   output logic       DONE
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] LAST_BAUD = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e        state;
   state_e        stateNext;
   logic [BW-1:0] baudCnt;
   logic [BW-1:0] baudNext;
   logic [2:0]    bitCnt;
   logic [2:0]    bitNext;
   logic [7:0]    shiftReg;
   logic [7:0]    shiftNext;
   logic          parReg;
   logic          parNext;
   logic          txdReg;
   logic          txdNext;
   logic          busyReg;
   logic          busyNext;
   logic          doneReg;
   logic          doneNext;
   logic          armed;
   logic          readyInt;
   logic          bitEnd;

   // READY stays low until the first edge after reset release
   assign readyInt = armed && (state == IDLE);
   assign bitEnd   = (baudCnt == LAST_BAUD);

   assign READY = readyInt;
   assign TXD   = txdReg;
   assign BUSY  = busyReg;
   assign DONE  = doneReg;

   // Arms the handshake one edge after reset is released
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
      end
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baudCnt  <= '0;
         bitCnt   <= '0;
         shiftReg <= '0;
         parReg   <= 1'b0;
         txdReg   <= 1'b1;
         busyReg  <= 1'b0;
         doneReg  <= 1'b0;
      end else begin
         state    <= stateNext;
         baudCnt  <= baudNext;
         bitCnt   <= bitNext;
         shiftReg <= shiftNext;
         parReg   <= parNext;
         txdReg   <= txdNext;
         busyReg  <= busyNext;
         doneReg  <= doneNext;
      end
   end

   // Next-state logic; line outputs are decoded from the next state
   always_comb begin
      stateNext = state;
      baudNext  = '0;
      bitNext   = bitCnt;
      shiftNext = shiftReg;
      parNext   = parReg;
      doneNext  = 1'b0;
      txdNext   = 1'b1;
      busyNext  = 1'b1;

      if (state != IDLE) begin
         baudNext = bitEnd ? '0 : baudCnt + 1'b1;
      end

      unique case (state)
         IDLE: begin
            bitNext = '0;
            if (VALID && readyInt) begin
               shiftNext = DIN;
               parNext   = PIN;
               stateNext = START;
            end
         end
         START: begin
            if (bitEnd) begin
               stateNext = DATA;
            end
         end
         DATA: begin
            if (bitEnd) begin
               shiftNext = {1'b0, shiftReg[7:1]};
               bitNext   = bitCnt + 3'd1;
               if (bitCnt == 3'd7) begin
                  stateNext = PARITY;
               end
            end
         end
         PARITY: begin
            if (bitEnd) begin
               stateNext = STOP;
            end
         end
         STOP: begin
            if (bitEnd) begin
               stateNext = IDLE;
               doneNext  = 1'b1;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase

      unique case (stateNext)
         IDLE: begin
            txdNext  = 1'b1;
            busyNext = 1'b0;
         end
         START:   txdNext = 1'b0;
         DATA:    txdNext = shiftNext[0];
         PARITY:  txdNext = parNext;
         STOP:    txdNext = 1'b1;
         default: begin
            txdNext  = 1'b1;
            busyNext = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx at 4 and 2 clocks per bit.
// Frames are captured at slot centres and compared to hand-built vectors.
module tb_parity_frame_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din4, din2;
   logic       pin4, pin2;
   logic       valid4, valid2;
   logic       ready4, txd4, busy4, done4;
   logic       ready2, txd2, busy2, done2;
   int         nVec = 0;
   int         nErr = 0;

   always #5 clk = ~clk;

   parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .DIN(din4), .PIN(pin4),
      .VALID(valid4), .READY(ready4), .TXD(txd4),
      .BUSY(busy4), .DONE(done4)
   );

   parity_frame_tx #(.CLKS_PER_BIT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .DIN(din2), .PIN(pin2),
      .VALID(valid2), .READY(ready2), .TXD(txd2),
      .BUSY(busy2), .DONE(done2)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      nVec++;
      if (obs !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic txdOf(input bit sel);
      return sel ? txd2 : txd4;
   endfunction
   function automatic logic busyOf(input bit sel);
      return sel ? busy2 : busy4;
   endfunction
   function automatic logic doneOf(input bit sel);
      return sel ? done2 : done4;
   endfunction
   function automatic logic readyOf(input bit sel);
      return sel ? ready2 : ready4;
   endfunction

   task automatic drive(input bit sel, input logic v,
                        input logic [7:0] d, input logic p);
      if (sel) begin
         valid2 = v; din2 = d; pin2 = p;
      end else begin
         valid4 = v; din4 = d; pin4 = p;
      end
   endtask

   // Offers a frame and returns just after the handshake edge
   task automatic offer(input string tag, input bit sel,
                        input logic [7:0] d, input logic p);
      int n;
      n = 0;
      @(negedge clk);
      drive(sel, 1'b1, d, p);
      while (!readyOf(sel) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 32'(readyOf(sel)), 32'd1);
      @(posedge clk);
   endtask

   // Captures one frame starting at the first START cycle
   task automatic rxFrame(input string tag, input bit sel, input int cpb,
                          input logic [10:0] expBits, input bit keep,
                          input logic [7:0] nd, input logic np,
                          input bit wiggle);
      logic [10:0] got;
      logic        slotVal;
      int          busyN, doneN, readyN, glitch;
      got = '0;
      slotVal = 1'b1;
      busyN = 0; doneN = 0; readyN = 0; glitch = 0;
      for (int k = 0; k < 11 * cpb; k++) begin
         @(negedge clk);
         if (k == 0) drive(sel, keep, nd, np);
         else if (wiggle)
            drive(sel, 1'($urandom), 8'($urandom), 1'($urandom));
         if (k % cpb == 0) slotVal = txdOf(sel);
         else if (txdOf(sel) !== slotVal) glitch++;
         if (k % cpb == cpb / 2) got[k / cpb] = txdOf(sel);
         busyN += int'(busyOf(sel));
         doneN += int'(doneOf(sel));
         readyN += int'(readyOf(sel));
      end
      check({tag, "_bits"}, 32'(got), 32'(expBits));
      check({tag, "_glitch"}, 32'(glitch), 32'd0);
      check({tag, "_busyCycles"}, 32'(busyN), 32'(11 * cpb));
      check({tag, "_doneInFrame"}, 32'(doneN), 32'd0);
      check({tag, "_readyInFrame"}, 32'(readyN), 32'd0);
      @(negedge clk);
      if (wiggle) drive(sel, 1'b0, nd, np);
      check({tag, "_done"}, 32'(doneOf(sel)), 32'd1);
      check({tag, "_busyEnd"}, 32'(busyOf(sel)), 32'd0);
      check({tag, "_txdIdle"}, 32'(txdOf(sel)), 32'd1);
      check({tag, "_readyIdle"}, 32'(readyOf(sel)), 32'd1);
      if (!keep) begin
         @(negedge clk);
         check({tag, "_doneOnce"}, 32'(doneOf(sel)), 32'd0);
         check({tag, "_readyAfter"}, 32'(readyOf(sel)), 32'd1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      #12;
      check("rst_txd", 32'(txd4), 32'd1);
      check("rst_busy", 32'(busy4), 32'd0);
      check("rst_done", 32'(done4), 32'd0);
      check("rst_ready", 32'(ready4), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_readyLow", 32'(ready4), 32'd0);
      @(negedge clk);
      check("rel_ready4", 32'(ready4), 32'd1);
      check("rel_ready2", 32'(ready2), 32'd1);

      // 5A with P=1
      offer("t1", 1'b0, 8'h5A, 1'b1);
      rxFrame("t1", 1'b0, 4, 11'b11010110100, 1'b0, 8'h00, 1'b0, 1'b0);

      // all-zero frame
      offer("t2", 1'b0, 8'h00, 1'b0);
      rxFrame("t2", 1'b0, 4, 11'b10000000000, 1'b0, 8'h00, 1'b0, 1'b0);

      // back-to-back with VALID held
      offer("t3a", 1'b0, 8'hFF, 1'b1);
      rxFrame("t3a", 1'b0, 4, 11'b11111111110, 1'b1, 8'h01, 1'b0, 1'b0);
      @(posedge clk);
      rxFrame("t3b", 1'b0, 4, 11'b10000000010, 1'b0, 8'h00, 1'b0, 1'b0);

      // inputs wiggled during the frame
      offer("t4", 1'b0, 8'hA5, 1'b0);
      rxFrame("t4", 1'b0, 4, 11'b10101001010, 1'b0, 8'h00, 1'b0, 1'b1);

      // reset during data bit 3
      offer("t5", 1'b0, 8'hF0, 1'b0);
      repeat (18) @(negedge clk);
      check("t5_txdBefore", 32'(txd4), 32'd0);
      check("t5_busyBefore", 32'(busy4), 32'd1);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      check("t5_txdAsync", 32'(txd4), 32'd1);
      check("t5_busyAsync", 32'(busy4), 32'd0);
      check("t5_readyRst", 32'(ready4), 32'd0);
      @(negedge clk);
      check("t5_doneRst1", 32'(done4), 32'd0);
      @(negedge clk);
      check("t5_doneRst2", 32'(done4), 32'd0);
      rst_n = 1'b1;
      #1;
      check("t5_readyLow", 32'(ready4), 32'd0);
      @(negedge clk);
      check("t5_readyUp", 32'(ready4), 32'd1);
      check("t5_doneAfter", 32'(done4), 32'd0);
      check("t5_txdAfter", 32'(txd4), 32'd1);
      offer("t5n", 1'b0, 8'h3C, 1'b0);
      rxFrame("t5n", 1'b0, 4, 11'b10001111000, 1'b0, 8'h00, 1'b0, 1'b0);

      // two clocks per bit
      offer("t6", 1'b1, 8'h81, 1'b1);
      rxFrame("t6", 1'b1, 2, 11'b11100000010, 1'b0, 8'h00, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
